// File: rtl/id_hazard_ctrl.sv
// Decode-stage hazard controller: shadows the EX/MEM/WB destinations and
// produces forwarding selects plus stall, bubble, flush and freeze controls.
module id_hazard_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [4:0]       id_rd,
    input  logic             id_rf_we,
    input  logic             id_is_load,
    input  logic             id_cmp_in_id,
    input  logic             id_redirect,
    input  logic             mem_busy,
    output logic             pc_we,
    output logic             if_id_we,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             pipe_hold,
    output logic             rf_rd1_forwarding_sel,
    output logic             rf_rd2_forwarding_sel,
    output logic [1:0]       fwd1_src,
    output logic [1:0]       fwd2_src,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int unsigned REG_W = 5;
    localparam int unsigned RES_W = 4;

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_HAZARD = 2'd1,
        S_FREEZE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [REG_W-1:0]   r_ex_rd;
    logic               r_ex_we;
    logic               r_ex_ld;
    logic [REG_W-1:0]   r_mem_rd;
    logic               r_mem_we;
    logic [REG_W-1:0]   r_wb_rd;
    logic               r_wb_we;
    logic [CNT_W-1:0]   r_stall_cnt;
    logic [RES_W-1:0]   w_res1;
    logic [RES_W-1:0]   w_res2;
    logic               w_hazard;

    // Result is {hazard, fwd_sel, fwd_src[1:0]}; youngest producer wins.
    function automatic logic [RES_W-1:0] resolve_src(
        input logic [REG_W-1:0] rs,
        input logic             used,
        input logic             cmp_in_id,
        input logic [REG_W-1:0] ex_rd,
        input logic             ex_we,
        input logic             ex_ld,
        input logic [REG_W-1:0] mem_rd,
        input logic             mem_we,
        input logic [REG_W-1:0] wb_rd,
        input logic             wb_we
    );
        logic [RES_W-1:0] res;
        res = '0;
        if (used && (rs != '0)) begin
            if (ex_we && (ex_rd == rs)) begin
                if (ex_ld || cmp_in_id) begin
                    res = 4'b1000;
                end else begin
                    res = 4'b0101;
                end
            end else if (mem_we && (mem_rd == rs)) begin
                res = 4'b0110;
            end else if (wb_we && (wb_rd == rs)) begin
                res = 4'b0111;
            end
        end
        return res;
    endfunction

    always_comb begin
        w_res1 = resolve_src(id_rs1, id_rs1_used, id_cmp_in_id, r_ex_rd, r_ex_we, r_ex_ld,
                             r_mem_rd, r_mem_we, r_wb_rd, r_wb_we);
        w_res2 = resolve_src(id_rs2, id_rs2_used, id_cmp_in_id, r_ex_rd, r_ex_we, r_ex_ld,
                             r_mem_rd, r_mem_we, r_wb_rd, r_wb_we);
        w_hazard = id_valid & (w_res1[3] | w_res2[3]);
    end

    // Next state and pipe controls: memory freeze outranks a data hazard.
    always_comb begin
        w_state_nxt           = r_state;
        pc_we                 = 1'b1;
        if_id_we              = 1'b1;
        if_id_flush           = 1'b0;
        id_ex_bubble          = 1'b0;
        pipe_hold             = 1'b0;
        rf_rd1_forwarding_sel = w_res1[2];
        rf_rd2_forwarding_sel = w_res2[2];
        fwd1_src              = w_res1[1:0];
        fwd2_src              = w_res2[1:0];

        if (mem_busy) begin
            w_state_nxt = S_FREEZE;
        end else if (w_hazard) begin
            w_state_nxt = S_HAZARD;
        end else begin
            w_state_nxt = S_RUN;
        end

        case (w_state_nxt)
            S_FREEZE: begin
                pc_we     = 1'b0;
                if_id_we  = 1'b0;
                pipe_hold = 1'b1;
            end
            S_HAZARD: begin
                pc_we        = 1'b0;
                if_id_we     = 1'b0;
                id_ex_bubble = 1'b1;
            end
            default: begin
                if_id_flush = id_redirect & id_valid;
            end
        endcase

        if (rst) begin
            pc_we                 = 1'b0;
            if_id_we              = 1'b0;
            if_id_flush           = 1'b1;
            id_ex_bubble          = 1'b1;
            pipe_hold             = 1'b0;
            rf_rd1_forwarding_sel = 1'b0;
            rf_rd2_forwarding_sel = 1'b0;
            fwd1_src              = 2'b00;
            fwd2_src              = 2'b00;
        end
    end

    // Shadow pipe and stall counter; a freeze holds everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_RUN;
            r_ex_rd     <= '0;
            r_ex_we     <= 1'b0;
            r_ex_ld     <= 1'b0;
            r_mem_rd    <= '0;
            r_mem_we    <= 1'b0;
            r_wb_rd     <= '0;
            r_wb_we     <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt != S_FREEZE) begin
                r_mem_rd <= r_ex_rd;
                r_mem_we <= r_ex_we;
                r_wb_rd  <= r_mem_rd;
                r_wb_we  <= r_mem_we;
                if (w_state_nxt == S_HAZARD) begin
                    r_ex_rd <= '0;
                    r_ex_we <= 1'b0;
                    r_ex_ld <= 1'b0;
                end else begin
                    r_ex_rd <= id_rd;
                    r_ex_we <= id_rf_we & id_valid;
                    r_ex_ld <= id_is_load & id_valid;
                end
            end
            if ((w_state_nxt == S_HAZARD) && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Bench for id_hazard_ctrl: cycle-by-cycle vector table with a queued
// scoreboard, plus a narrow-counter instance to exercise saturation.
module tb_id_hazard_ctrl;

    localparam int K_RUN = 0;
    localparam int K_HAZ = 1;
    localparam int K_FRZ = 2;
    localparam int K_RST = 3;

    typedef struct {
        logic       rst;
        logic       valid;
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
        logic [4:0] rd;
        logic       we;
        logic       ld;
        logic       cmp;
        logic       redir;
        logic       busy;
    } stim_t;

    typedef struct {
        logic        pc_we;
        logic        if_id_we;
        logic        flush;
        logic        bubble;
        logic        hold;
        logic        sel1;
        logic        sel2;
        logic [1:0]  src1;
        logic [1:0]  src2;
        logic [31:0] cnt;
    } exp_t;

    typedef struct {
        string name;
        stim_t s;
        exp_t  e;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_rs1_used;
    logic        id_rs2_used;
    logic [4:0]  id_rd;
    logic        id_rf_we;
    logic        id_is_load;
    logic        id_cmp_in_id;
    logic        id_redirect;
    logic        mem_busy;

    logic        pc_we, if_id_we, if_id_flush, id_ex_bubble, pipe_hold;
    logic        sel1, sel2;
    logic [1:0]  src1, src2;
    logic [31:0] stall_cnt;

    logic        s_pc_we, s_if_id_we, s_if_id_flush, s_id_ex_bubble, s_pipe_hold;
    logic        s_sel1, s_sel2;
    logic [1:0]  s_src1, s_src2;
    logic [1:0]  s_stall_cnt;

    int n_checks = 0;
    int n_errors = 0;

    vec_t  tbl[$];
    exp_t  exp_q[$];
    string name_q[$];

    always #5 clk = ~clk;

    id_hazard_ctrl #(.CNT_W(32)) u_dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_rf_we(id_rf_we), .id_is_load(id_is_load),
        .id_cmp_in_id(id_cmp_in_id), .id_redirect(id_redirect), .mem_busy(mem_busy),
        .pc_we(pc_we), .if_id_we(if_id_we), .if_id_flush(if_id_flush),
        .id_ex_bubble(id_ex_bubble), .pipe_hold(pipe_hold),
        .rf_rd1_forwarding_sel(sel1), .rf_rd2_forwarding_sel(sel2),
        .fwd1_src(src1), .fwd2_src(src2), .stall_cnt(stall_cnt)
    );

    id_hazard_ctrl #(.CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_rf_we(id_rf_we), .id_is_load(id_is_load),
        .id_cmp_in_id(id_cmp_in_id), .id_redirect(id_redirect), .mem_busy(mem_busy),
        .pc_we(s_pc_we), .if_id_we(s_if_id_we), .if_id_flush(s_if_id_flush),
        .id_ex_bubble(s_id_ex_bubble), .pipe_hold(s_pipe_hold),
        .rf_rd1_forwarding_sel(s_sel1), .rf_rd2_forwarding_sel(s_sel2),
        .fwd1_src(s_src1), .fwd2_src(s_src2), .stall_cnt(s_stall_cnt)
    );

    function automatic stim_t st(input logic r, input logic v,
                                 input logic [4:0] a, input logic ua,
                                 input logic [4:0] b, input logic ub,
                                 input logic [4:0] d, input logic w, input logic l,
                                 input logic c, input logic rd_dir, input logic bz);
        stim_t s;
        s.rst = r; s.valid = v; s.rs1 = a; s.u1 = ua; s.rs2 = b; s.u2 = ub;
        s.rd = d; s.we = w; s.ld = l; s.cmp = c; s.redir = rd_dir; s.busy = bz;
        return s;
    endfunction

    function automatic exp_t ex(input int kind, input logic [1:0] a, input logic [1:0] b,
                                input logic fl, input int cnt);
        exp_t e;
        e.pc_we = 1'b1; e.if_id_we = 1'b1; e.flush = fl; e.bubble = 1'b0; e.hold = 1'b0;
        e.src1 = a; e.src2 = b;
        e.cnt = 32'(cnt);
        case (kind)
            K_HAZ: begin e.pc_we = 1'b0; e.if_id_we = 1'b0; e.bubble = 1'b1; end
            K_FRZ: begin e.pc_we = 1'b0; e.if_id_we = 1'b0; e.hold = 1'b1; end
            K_RST: begin
                e.pc_we = 1'b0; e.if_id_we = 1'b0; e.flush = 1'b1; e.bubble = 1'b1;
                e.src1 = 2'b00; e.src2 = 2'b00;
            end
            default: ;
        endcase
        e.sel1 = (e.src1 != 2'b00);
        e.sel2 = (e.src2 != 2'b00);
        return e;
    endfunction

    function automatic vec_t v(input string n, input stim_t s, input exp_t e);
        vec_t r;
        r.name = n; r.s = s; r.e = e;
        return r;
    endfunction

    task automatic chk(input string n, input string f, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", n, f, act, exp);
        end
    endtask

    task automatic drive(input stim_t s);
        rst = s.rst; id_valid = s.valid;
        id_rs1 = s.rs1; id_rs1_used = s.u1; id_rs2 = s.rs2; id_rs2_used = s.u2;
        id_rd = s.rd; id_rf_we = s.we; id_is_load = s.ld;
        id_cmp_in_id = s.cmp; id_redirect = s.redir; mem_busy = s.busy;
    endtask

    // Pop the oldest expectation and compare it with what the DUTs show now.
    task automatic check_pop();
        exp_t  e;
        string n;
        logic [8:0] ctl_m, ctl_s, ctl_e;
        logic [31:0] sat;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        chk(n, "pc_we", 32'(pc_we), 32'(e.pc_we));
        chk(n, "if_id_we", 32'(if_id_we), 32'(e.if_id_we));
        chk(n, "if_id_flush", 32'(if_id_flush), 32'(e.flush));
        chk(n, "id_ex_bubble", 32'(id_ex_bubble), 32'(e.bubble));
        chk(n, "pipe_hold", 32'(pipe_hold), 32'(e.hold));
        chk(n, "sel1", 32'(sel1), 32'(e.sel1));
        chk(n, "sel2", 32'(sel2), 32'(e.sel2));
        chk(n, "fwd1_src", 32'(src1), 32'(e.src1));
        chk(n, "fwd2_src", 32'(src2), 32'(e.src2));
        chk(n, "stall_cnt", stall_cnt, e.cnt);
        ctl_e = {e.pc_we, e.if_id_we, e.flush, e.bubble, e.hold, e.sel1, e.sel2, e.src1};
        ctl_m = {s_pc_we, s_if_id_we, s_if_id_flush, s_id_ex_bubble, s_pipe_hold,
                 s_sel1, s_sel2, s_src1};
        chk(n, "sat_ctl", 32'(ctl_m), 32'(ctl_e));
        chk(n, "sat_src2", 32'(s_src2), 32'(e.src2));
        sat = (e.cnt > 32'd3) ? 32'd3 : e.cnt;
        chk(n, "sat_cnt", 32'(s_stall_cnt), sat);
    endtask

    task automatic run_vec(input vec_t t);
        @(posedge clk);
        #1;
        drive(t.s);
        exp_q.push_back(t.e);
        name_q.push_back(t.name);
        @(negedge clk);
        check_pop();
    endtask

    initial begin
        drive(st(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(posedge clk);

        tbl.push_back(v("reset",      st(1,0, 0,0, 0,0, 0,0,0,0,0,0), ex(K_RST,0,0,0,0)));
        tbl.push_back(v("add_x5",     st(0,1, 1,1, 2,1, 5,1,0,0,0,0), ex(K_RUN,0,0,0,0)));
        tbl.push_back(v("sub_fwd_ex", st(0,1, 5,1, 3,1, 6,1,0,0,0,0), ex(K_RUN,1,0,0,0)));
        tbl.push_back(v("lw_x7",      st(0,1, 1,1, 0,0, 7,1,1,0,0,0), ex(K_RUN,0,0,0,0)));
        tbl.push_back(v("ldu_stall",  st(0,1, 7,1, 7,1, 8,1,0,0,0,0), ex(K_HAZ,0,0,0,0)));
        tbl.push_back(v("ldu_fwd",    st(0,1, 7,1, 7,1, 8,1,0,0,0,0), ex(K_RUN,2,2,0,1)));
        tbl.push_back(v("addi_x9",    st(0,1, 0,1, 0,0, 9,1,0,0,0,0), ex(K_RUN,0,0,0,1)));
        tbl.push_back(v("beq_stall",  st(0,1, 9,1, 4,1, 0,0,0,1,1,0), ex(K_HAZ,0,0,0,1)));
        tbl.push_back(v("beq_flush",  st(0,1, 9,1, 4,1, 0,0,0,1,1,0), ex(K_RUN,2,0,1,2)));
        tbl.push_back(v("target",     st(0,1, 0,0, 0,0, 0,0,0,0,0,0), ex(K_RUN,0,0,0,2)));
        tbl.push_back(v("lw_x0",      st(0,1, 1,1, 0,0, 0,1,1,0,0,0), ex(K_RUN,0,0,0,2)));
        tbl.push_back(v("rd_x0",      st(0,1, 0,1, 0,1,10,1,0,0,0,0), ex(K_RUN,0,0,0,2)));
        tbl.push_back(v("nop_a",      st(0,1, 0,0, 0,0, 0,0,0,0,0,0), ex(K_RUN,0,0,0,2)));
        tbl.push_back(v("nop_b",      st(0,1, 0,0, 0,0, 0,0,0,0,0,0), ex(K_RUN,0,0,0,2)));
        tbl.push_back(v("wb_fwd",     st(0,1,10,1, 1,1,11,1,0,0,0,0), ex(K_RUN,3,0,0,2)));
        tbl.push_back(v("lw_x12",     st(0,1, 2,1, 0,0,12,1,1,0,0,0), ex(K_RUN,0,0,0,2)));
        tbl.push_back(v("frz_1",      st(0,1,12,1,11,1,13,1,0,0,1,1), ex(K_FRZ,0,2,0,2)));
        tbl.push_back(v("frz_2",      st(0,1,12,1,11,1,13,1,0,0,1,1), ex(K_FRZ,0,2,0,2)));
        tbl.push_back(v("frz_3",      st(0,1,12,1,11,1,13,1,0,0,0,1), ex(K_FRZ,0,2,0,2)));
        tbl.push_back(v("frz_haz",    st(0,1,12,1,11,1,13,1,0,0,0,0), ex(K_HAZ,0,2,0,2)));
        tbl.push_back(v("frz_fwd",    st(0,1,12,1,11,1,13,1,0,0,0,0), ex(K_RUN,2,3,0,3)));
        tbl.push_back(v("lw_x14",     st(0,1, 1,1, 0,0,14,1,1,0,0,0), ex(K_RUN,0,0,0,3)));
        tbl.push_back(v("haz_x14",    st(0,1,14,1,14,1,15,1,0,0,0,0), ex(K_HAZ,0,0,0,3)));
        tbl.push_back(v("rst_mid",    st(1,1,14,1,14,1,15,1,0,0,0,0), ex(K_RST,0,0,0,4)));
        tbl.push_back(v("post_rst",   st(0,1,14,1,14,1,15,1,0,0,0,0), ex(K_RUN,0,0,0,0)));

        foreach (tbl[i]) run_vec(tbl[i]);

        // Branch consuming a load result in ID: one stall, then MEM forward.
        run_vec(v("lw_x16",   st(0,1, 2,1, 0,0,16,1,1,0,0,0), ex(K_RUN,0,0,0,0)));
        run_vec(v("bld_stall",st(0,1,16,1,15,1, 0,0,0,1,0,0), ex(K_HAZ,0,2,0,0)));
        run_vec(v("bld_fwd",  st(0,1,16,1,15,1, 0,0,0,1,0,0), ex(K_RUN,2,3,0,1)));

        // An invalid ID slot must neither flush nor create a producer.
        run_vec(v("inv_slot", st(0,0, 0,0, 0,0,17,1,0,0,1,0), ex(K_RUN,0,0,0,1)));
        run_vec(v("rd_x17",   st(0,1,17,1, 0,0,18,1,0,0,0,0), ex(K_RUN,0,0,0,1)));

        if (exp_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard: %0d expectations left, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
